// File: rtl/sh7034_mac_seq_pkg.sv
// Shared SH7034 MAC definitions: opcode encodings, sequencer state type and
// the word byte-lane helper used for 16-bit operand fetches.
package sh7034_mac_seq_pkg;

  localparam logic [3:0] MACOP_LDS_R = 4'b0100;
  localparam logic [3:0] MACOP_LDS_M = 4'b1000;
  localparam logic [3:0] MACOP_MULU  = 4'b0110;
  localparam logic [3:0] MACOP_MULS  = 4'b0111;
  localparam logic [3:0] MACOP_MACW  = 4'b1011;
  localparam logic [3:0] MACOP_CLR   = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_WR1  = 3'd2,
    S_RD2  = 3'd3,
    S_WR2  = 3'd4,
    S_WAIT = 3'd5
  } mac_seq_state_t;

  // Big-endian word lanes: the upper half of the longword sits at offset 0.
  function automatic logic [3:0] word_ba(input logic a1);
    return a1 ? 4'b0011 : 4'b1100;
  endfunction

  function automatic logic is_mac_op(input logic [3:0] op);
    return (op == MACOP_LDS_R) || (op == MACOP_LDS_M) || (op == MACOP_MULU) ||
           (op == MACOP_MULS)  || (op == MACOP_MACW)  || (op == MACOP_CLR);
  endfunction

endpackage

// File: rtl/sh7034_mac_seq.sv
// MAC-operation sequencer: turns MAC-class instructions into operand fetches
// and single-cycle MAC unit write commands, reporting post-increments and busy.
//
// state  | meaning
// IDLE   | ready for an instruction; LDS Rm / CLRMAC / MUL issue from here
// RD1    | MAC.W first operand read at Rn
// WR1    | load MA with the first operand, post-increment Rn
// RD2    | MAC.W second operand (Rm or Rn+2), or LDS @Rm+ longword read
// WR2    | load MB and launch MAC.W, or write MACx for LDS @Rm+; increment Rm
// WAIT   | one cycle for the MAC unit result to settle
module sh7034_mac_seq
  import sh7034_mac_seq_pkg::*;
#(
  parameter int ADDR_W = 28
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE_R,
  input  logic              ID_VALID,
  input  logic [3:0]        ID_OP,
  input  logic [1:0]        ID_SEL,
  input  logic [31:0]       ID_RM,
  input  logic [31:0]       ID_RN,
  input  logic              ID_SAME,
  input  logic              ID_S,
  output logic              ID_READY,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [3:0]        MEM_BA,
  output logic              MEM_REQ,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_DI,
  output logic [ADDR_W-1:0] MAC_A,
  output logic [31:0]       MAC_DI,
  output logic [1:0]        MAC_SEL,
  output logic [3:0]        MAC_OP,
  output logic              MAC_S,
  output logic              MAC_WE,
  output logic              RM_INC,
  output logic              RN_INC,
  output logic              INC_LONG,
  output logic              MAC_BUSY
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] WORD_STEP  = {{(ADDR_W-2){1'b0}}, 2'b10};

  mac_seq_state_t    state;
  logic [3:0]        op_q;
  logic [1:0]        sel_q;
  logic              s_q;
  logic              same_q;
  logic [ADDR_W-1:0] rm_q;
  logic [ADDR_W-1:0] rn_q;
  logic [ADDR_W-1:0] rd2_addr;
  logic              unused_rn_hi;

  assign unused_rn_hi = ^ID_RN[31:ADDR_W];

  // Second MAC.W operand: Rn+2 when both operands come from the same register.
  assign rd2_addr = (same_q ? (rn_q + WORD_STEP) : rm_q) & ALIGN_MASK;

  // Accept only known opcodes, only from IDLE, and never while reset is held.
  assign ID_READY = !RST && (state == S_IDLE) && ID_VALID && is_mac_op(ID_OP);
  assign MAC_BUSY = (state != S_IDLE);

  // Sequencer state, latched instruction fields and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      op_q     <= '0;
      sel_q    <= '0;
      s_q      <= 1'b0;
      same_q   <= 1'b0;
      rm_q     <= '0;
      rn_q     <= '0;
      MEM_A    <= '0;
      MEM_BA   <= '0;
      MEM_REQ  <= 1'b0;
      MAC_A    <= '0;
      MAC_DI   <= '0;
      MAC_SEL  <= '0;
      MAC_OP   <= '0;
      MAC_S    <= 1'b0;
      MAC_WE   <= 1'b0;
      RM_INC   <= 1'b0;
      RN_INC   <= 1'b0;
      INC_LONG <= 1'b0;
    end else if (CE_R) begin
      MAC_WE   <= 1'b0;
      MAC_SEL  <= '0;
      MAC_OP   <= '0;
      MAC_DI   <= '0;
      MAC_A    <= '0;
      MAC_S    <= 1'b0;
      RM_INC   <= 1'b0;
      RN_INC   <= 1'b0;
      INC_LONG <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ID_READY) begin
            op_q   <= ID_OP;
            sel_q  <= ID_SEL;
            s_q    <= ID_S;
            same_q <= ID_SAME;
            rm_q   <= ID_RM[ADDR_W-1:0];
            rn_q   <= ID_RN[ADDR_W-1:0];
            case (ID_OP)
              MACOP_LDS_R, MACOP_CLR: begin
                MAC_WE  <= 1'b1;
                MAC_OP  <= ID_OP;
                MAC_SEL <= ID_SEL;
                MAC_DI  <= ID_RM;
              end
              MACOP_MULU, MACOP_MULS: begin
                MAC_WE  <= 1'b1;
                MAC_OP  <= ID_OP;
                MAC_SEL <= 2'b10;
                MAC_DI  <= {ID_RN[15:0], ID_RM[15:0]};
                state   <= S_WAIT;
              end
              MACOP_LDS_M: begin
                MEM_REQ <= 1'b1;
                MEM_A   <= ID_RM[ADDR_W-1:0] & ALIGN_MASK;
                MEM_BA  <= 4'b1111;
                state   <= S_RD2;
              end
              MACOP_MACW: begin
                MEM_REQ <= 1'b1;
                MEM_A   <= ID_RN[ADDR_W-1:0] & ALIGN_MASK;
                MEM_BA  <= word_ba(ID_RN[1]);
                state   <= S_RD1;
              end
              default: ;
            endcase
          end
        end
        S_RD1: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            MAC_WE  <= 1'b1;
            MAC_OP  <= op_q;
            MAC_SEL <= 2'b01;
            MAC_DI  <= MEM_DI;
            MAC_A   <= MEM_A;
            RN_INC  <= 1'b1;
            state   <= S_WR1;
          end
        end
        S_WR1: begin
          MEM_REQ <= 1'b1;
          MEM_A   <= rd2_addr;
          MEM_BA  <= word_ba(rd2_addr[1]);
          state   <= S_RD2;
        end
        S_RD2: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            MAC_WE  <= 1'b1;
            MAC_OP  <= op_q;
            MAC_DI  <= MEM_DI;
            MAC_A   <= MEM_A;
            RM_INC  <= 1'b1;
            if (op_q == MACOP_MACW) begin
              MAC_SEL <= 2'b10;
              MAC_S   <= s_q;
            end else begin
              MAC_SEL  <= sel_q;
              INC_LONG <= 1'b1;
            end
            state <= S_WR2;
          end
        end
        S_WR2:   state <= (op_q == MACOP_MACW) ? S_WAIT : S_IDLE;
        S_WAIT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
